// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC transmit path.
// Also used by the future RX FCS verifier.
package mac_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    UNDERRUN,
    TRUNC,
    DRAIN,
    IFG
  } tx_state_t;

endpackage

// File: rtl/mac_crc32_d8.sv
// Byte-wide reflected CRC32 next-state logic.
// Data bits are consumed LSB first.
module mac_crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = (crc_out >> 1) ^
                ((crc_out[0] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet TX framer: preamble, payload, pad, FCS and IFG
// onto a registered GMII-style byte stream.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IFG_BYTES    = 12,
  parameter bit CRC_APPEND   = 1'b1
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  mac_rnet_data_in,
  input  logic        mac_rnet_valid_in,
  output logic        mac_rnet_ready_out,
  input  logic        mac_rnet_last_in,
  output logic [7:0]  mac_tphy_data_out,
  output logic        mac_tphy_valid_out,
  output logic        mac_tphy_err_out,
  output logic [31:0] mac_tx_frames_out,
  output logic [15:0] mac_tx_errors_out
);

  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int IW = $clog2(IFG_BYTES + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAME);
  localparam logic [3:0]    PRE_C = 4'(PREAMBLE_LEN);
  localparam logic [IW-1:0] IFG_C = IW'(IFG_BYTES - 1);

  if (MIN_FRAME > MAX_FRAME) begin : g_min_max
    $error("MIN_FRAME must not exceed MAX_FRAME");
  end
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_pre
    $error("PREAMBLE_LEN must be 1..15");
  end
  if (IFG_BYTES < 1) begin : g_ifg
    $error("IFG_BYTES must be at least 1");
  end

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   crc_q, crc_d, crc_nxt, crc_inv;
  logic [7:0]    crc_byte;
  logic [3:0]    pre_q, pre_d;
  logic [1:0]    fcs_q, fcs_d;
  logic [IW-1:0] ifg_q, ifg_d;
  logic          last_q, last_d;
  logic [7:0]    data_d;
  logic          valid_d, err_d;
  logic          frame_done, frame_err;
  logic          take;

  assign take     = mac_rnet_valid_in & mac_rnet_ready_out;
  assign cnt_inc  = cnt_q + 1'b1;
  assign crc_inv  = ~crc_q;
  assign crc_byte = (state_q == PAD) ? 8'h00 : mac_rnet_data_in;

  // Error/drain states keep swallowing input until the frame's last byte.
  assign mac_rnet_ready_out = (state_q == PAYLOAD) |
    ((state_q inside {UNDERRUN, TRUNC, DRAIN}) & ~last_q);

  mac_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    pre_d      = pre_q;
    fcs_d      = fcs_q;
    ifg_d      = ifg_q;
    last_d     = last_q;
    data_d     = 8'h00;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mac_rnet_valid_in) begin
          state_d = PREAMBLE;
          data_d  = PREAMBLE_BYTE;
          valid_d = 1'b1;
          pre_d   = 4'd1;
        end
      end
      PREAMBLE: begin
        valid_d = 1'b1;
        if (pre_q < PRE_C) begin
          data_d = PREAMBLE_BYTE;
          pre_d  = pre_q + 1'b1;
        end else begin
          data_d  = SFD_BYTE;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        valid_d = 1'b1;
        if (cnt_q == MAX_C) begin
          err_d     = 1'b1;
          frame_err = 1'b1;
          state_d   = TRUNC;
          last_d    = take & mac_rnet_last_in;
        end else if (mac_rnet_valid_in) begin
          data_d = mac_rnet_data_in;
          crc_d  = crc_nxt;
          cnt_d  = cnt_inc;
          if (mac_rnet_last_in) begin
            if (int'(cnt_inc) < MIN_FRAME) begin
              state_d = PAD;
            end else if (CRC_APPEND) begin
              state_d = FCS;
            end else begin
              state_d    = IFG;
              frame_done = 1'b1;
            end
          end
        end else begin
          err_d     = 1'b1;
          frame_err = 1'b1;
          state_d   = UNDERRUN;
        end
      end
      PAD: begin
        valid_d = 1'b1;
        crc_d   = crc_nxt;
        cnt_d   = cnt_inc;
        if (int'(cnt_inc) >= MIN_FRAME) begin
          if (CRC_APPEND) begin
            state_d = FCS;
          end else begin
            state_d    = IFG;
            frame_done = 1'b1;
          end
        end
      end
      FCS: begin
        valid_d = 1'b1;
        data_d  = crc_inv[{fcs_q, 3'b000} +: 8];
        fcs_d   = fcs_q + 1'b1;
        if (fcs_q == 2'd3) begin
          state_d    = IFG;
          frame_done = 1'b1;
        end
      end
      UNDERRUN, TRUNC: begin
        state_d = DRAIN;
        if (take & mac_rnet_last_in) last_d = 1'b1;
      end
      DRAIN: begin
        if (last_q | (take & mac_rnet_last_in)) state_d = IFG;
      end
      IFG: begin
        ifg_d = ifg_q + 1'b1;
        if (ifg_q == IFG_C) begin
          state_d = IDLE;
          ifg_d   = '0;
          cnt_d   = '0;
          crc_d   = CRC32_INIT;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      crc_q              <= CRC32_INIT;
      pre_q              <= '0;
      fcs_q              <= '0;
      ifg_q              <= '0;
      last_q             <= 1'b0;
      mac_tphy_data_out  <= 8'h00;
      mac_tphy_valid_out <= 1'b0;
      mac_tphy_err_out   <= 1'b0;
      mac_tx_frames_out  <= '0;
      mac_tx_errors_out  <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      crc_q              <= crc_d;
      pre_q              <= pre_d;
      fcs_q              <= fcs_d;
      ifg_q              <= ifg_d;
      last_q             <= last_d;
      mac_tphy_data_out  <= data_d;
      mac_tphy_valid_out <= valid_d;
      mac_tphy_err_out   <= err_d;
      if (frame_done) mac_tx_frames_out <= mac_tx_frames_out + 32'd1;
      if (frame_err && mac_tx_errors_out != 16'hFFFF) begin
        mac_tx_errors_out <= mac_tx_errors_out + 16'd1;
      end
    end
  end

endmodule
